// File: rtl/tree_sum_accumulator.sv
// Accumulates N_CHUNKS consecutive signed tree-adder sums into one wide result.
// Valid/ready on both sides; registered output with sticky signed-overflow flag.
module tree_sum_accumulator #(
    parameter int P        = 8,
    parameter int ACC_W    = 16,
    parameter int N_CHUNKS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [P-1:0]     in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);

    localparam int CNT_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_CHUNKS - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    out_state_t       state_reg;
    out_state_t       state_next;

    logic [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0] chunk_cnt_reg;
    logic             ovf_sticky_reg;
    logic [ACC_W-1:0] out_acc_reg;
    logic             out_ovf_reg;

    logic [ACC_W-1:0] in_ext;
    logic [ACC_W-1:0] sum;
    logic             add_ovf;
    logic             accept;
    logic             last_beat;

    generate
        if (ACC_W > P) begin : g_sext
            assign in_ext = {{(ACC_W - P){in_sum[P-1]}}, in_sum};
        end else begin : g_same
            assign in_ext = in_sum;
        end
    endgenerate

    assign sum     = acc_reg + in_ext;
    // Signed overflow: operands agree in sign but the wrapped sum does not.
    assign add_ovf = (acc_reg[ACC_W-1] == in_ext[ACC_W-1]) &&
                     (sum[ACC_W-1] != acc_reg[ACC_W-1]);

    assign in_ready  = (state_reg == EMPTY) || out_ready;
    assign accept    = in_valid && in_ready;
    assign last_beat = accept && (chunk_cnt_reg == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: begin
                if (last_beat) state_next = FULL;
            end
            FULL: begin
                if (last_beat)      state_next = FULL;
                else if (out_ready) state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_reg == FULL);
        out_acc   = out_acc_reg;
        out_ovf   = out_ovf_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg        <= '0;
            chunk_cnt_reg  <= '0;
            ovf_sticky_reg <= 1'b0;
            out_acc_reg    <= '0;
            out_ovf_reg    <= 1'b0;
        end else if (accept) begin
            if (last_beat) begin
                out_acc_reg    <= sum;
                out_ovf_reg    <= ovf_sticky_reg | add_ovf;
                acc_reg        <= '0;
                chunk_cnt_reg  <= '0;
                ovf_sticky_reg <= 1'b0;
            end else begin
                acc_reg        <= sum;
                chunk_cnt_reg  <= chunk_cnt_reg + 1'b1;
                ovf_sticky_reg <= ovf_sticky_reg | add_ovf;
            end
        end
    end

endmodule

// File: tb/tb_tree_sum_accumulator.sv
// Scoreboard bench: three instances (16-bit/N=4, 8-bit/N=4, 16-bit/N=1) driven with
// directed groups; monitors pop expected {acc,ovf} whenever a result is consumed.
module tb_tree_sum_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int stalls = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: ACC_W=16, N=4
    logic        a_in_valid = 1'b0, a_out_ready = 1'b1;
    logic [7:0]  a_in_sum = '0;
    logic        a_in_ready, a_out_valid, a_out_ovf;
    logic [15:0] a_out_acc;
    // Instance B: ACC_W=8, N=4
    logic        b_in_valid = 1'b0, b_out_ready = 1'b1;
    logic [7:0]  b_in_sum = '0;
    logic        b_in_ready, b_out_valid, b_out_ovf;
    logic [7:0]  b_out_acc;
    // Instance C: ACC_W=16, N=1
    logic        c_in_valid = 1'b0, c_out_ready = 1'b1;
    logic [7:0]  c_in_sum = '0;
    logic        c_in_ready, c_out_valid, c_out_ovf;
    logic [15:0] c_out_acc;

    tree_sum_accumulator #(.P(8), .ACC_W(16), .N_CHUNKS(4)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sum(a_in_sum),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_acc(a_out_acc), .out_ovf(a_out_ovf));
    tree_sum_accumulator #(.P(8), .ACC_W(8), .N_CHUNKS(4)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sum(b_in_sum),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_acc(b_out_acc), .out_ovf(b_out_ovf));
    tree_sum_accumulator #(.P(8), .ACC_W(16), .N_CHUNKS(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_sum(c_in_sum),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_acc(c_out_acc), .out_ovf(c_out_ovf));

    logic [16:0] exp_a[$];
    logic [8:0]  exp_b[$];
    logic [16:0] exp_c[$];
    int          c_pop_cyc[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            if (exp_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected got acc=%0h ovf=%0b want=none", a_out_acc, a_out_ovf);
            end else begin
                logic [16:0] e;
                e = exp_a.pop_front();
                check("a_result", {15'd0, a_out_acc, a_out_ovf}, {15'd0, e});
                $display("A result acc=%0d ovf=%0b cyc=%0d", $signed(a_out_acc), a_out_ovf, cyc);
            end
        end
        if (!rst && b_out_valid && b_out_ready) begin
            if (exp_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected got acc=%0h ovf=%0b want=none", b_out_acc, b_out_ovf);
            end else begin
                logic [8:0] e;
                e = exp_b.pop_front();
                check("b_result", {23'd0, b_out_acc, b_out_ovf}, {23'd0, e});
                $display("B result acc=%0d ovf=%0b cyc=%0d", $signed(b_out_acc), b_out_ovf, cyc);
            end
        end
        if (!rst && c_out_valid && c_out_ready) begin
            if (exp_c.size() == 0) begin
                checks++; errors++;
                $display("FAIL c_unexpected got acc=%0h ovf=%0b want=none", c_out_acc, c_out_ovf);
            end else begin
                logic [16:0] e;
                e = exp_c.pop_front();
                check("c_result", {15'd0, c_out_acc, c_out_ovf}, {15'd0, e});
                c_pop_cyc.push_back(cyc);
                $display("C result acc=%0d ovf=%0b cyc=%0d", $signed(c_out_acc), c_out_ovf, cyc);
            end
        end
    end

    function automatic logic rdy(input int sel);
        case (sel)
            0:       return a_in_ready;
            1:       return b_in_ready;
            default: return c_in_ready;
        endcase
    endfunction

    // Present one beat; returns just after the edge on which it was accepted.
    task automatic beat(input int sel, input logic [7:0] v);
        int n;
        n = 0;
        case (sel)
            0:       begin a_in_valid = 1'b1; a_in_sum = v; end
            1:       begin b_in_valid = 1'b1; b_in_sum = v; end
            default: begin c_in_valid = 1'b1; c_in_sum = v; end
        endcase
        @(negedge clk);
        while (!rdy(sel) && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n > 0) stalls++;
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL beat_timeout sel=%0d got=no_ready want=ready", sel);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        c_in_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        wait_cycles(2);
        rst = 1'b0;
        @(negedge clk);
        check("reset_a_valid", {31'd0, a_out_valid}, 32'd0);
        check("reset_a_acc", {16'd0, a_out_acc}, 32'd0);
        check("reset_a_ready", {31'd0, a_in_ready}, 32'd1);
        check("reset_b_ovf", {31'd0, b_out_ovf}, 32'd0);
        @(posedge clk); #1;

        // 1: 10,-3,100,5 -> 112, valid for exactly one cycle right after beat 4
        exp_a.push_back({16'd112, 1'b0});
        beat(0, 8'd10); beat(0, 8'hFD); beat(0, 8'd100); beat(0, 8'd5);
        idle_all();
        @(negedge clk);
        check("t1_valid_after", {31'd0, a_out_valid}, 32'd1);
        check("t1_acc_after", {16'd0, a_out_acc}, 32'd112);
        @(negedge clk);
        check("t1_valid_one_cycle", {31'd0, a_out_valid}, 32'd0);
        wait_cycles(1);

        // 2: two groups streamed with no gaps; never any backpressure
        stalls = 0;
        exp_a.push_back({16'd10, 1'b0});
        exp_a.push_back({16'hFFF6, 1'b0});
        for (int i = 1; i <= 4; i++) beat(0, 8'(i));
        for (int i = 1; i <= 4; i++) beat(0, 8'(-i));
        idle_all();
        check("t2_no_stall", stalls, 32'd0);
        wait_cycles(3);

        // 3: hold result 8 with out_ready=0; next group must stall then complete to 26
        a_out_ready = 1'b0;
        exp_a.push_back({16'd8, 1'b0});
        exp_a.push_back({16'd26, 1'b0});
        for (int i = 0; i < 4; i++) beat(0, 8'd2);
        fork
            begin
                beat(0, 8'd5); beat(0, 8'd6); beat(0, 8'd7); beat(0, 8'd8);
                idle_all();
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("t3_blocked", {15'd0, a_in_ready, a_out_acc}, {15'd0, 1'b0, 16'd8});
                end
                @(posedge clk); #1;
                a_out_ready = 1'b1;
            end
        join
        wait_cycles(3);
        check("t3_drained", exp_a.size(), 32'd0);

        // 4: 8-bit accumulator wraps 508 -> -4 with overflow, then clean group
        exp_b.push_back({8'hFC, 1'b1});
        exp_b.push_back({8'd4, 1'b0});
        for (int i = 0; i < 4; i++) beat(1, 8'd127);
        for (int i = 0; i < 4; i++) beat(1, 8'd1);
        idle_all();
        wait_cycles(3);
        check("t4_drained", exp_b.size(), 32'd0);

        // 5: reset mid-group discards the partial and clears the output register
        beat(0, 8'd9); beat(0, 8'd9);
        idle_all();
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        @(negedge clk);
        check("t5_rst_valid", {31'd0, a_out_valid}, 32'd0);
        check("t5_rst_acc", {16'd0, a_out_acc}, 32'd0);
        check("t5_rst_ovf", {31'd0, a_out_ovf}, 32'd0);
        @(posedge clk); #1;
        exp_a.push_back({16'd10, 1'b0});
        for (int i = 1; i <= 4; i++) beat(0, 8'(i));
        idle_all();
        wait_cycles(3);
        check("t5_drained", exp_a.size(), 32'd0);

        // 6: N=1, -7 then 8 on consecutive cycles
        exp_c.push_back({16'hFFF9, 1'b0});
        exp_c.push_back({16'd8, 1'b0});
        beat(2, 8'hF9); beat(2, 8'd8);
        idle_all();
        wait_cycles(3);
        check("t6_pops", c_pop_cyc.size(), 32'd2);
        if (c_pop_cyc.size() == 2)
            check("t6_back_to_back", c_pop_cyc[1] - c_pop_cyc[0], 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
